bit_majority_downsample: RTL

BIT_MAJORITY_DOWNSAMPLE -- requirements
Module: bit_majority_downsample

---
 rtl/bit_majority_downsample.sv | 111 +++++++++++
 1 files changed

// File: rtl/bit_majority_downsample.sv
// bit_majority_downsample
// Collapses SAMPLE_PER_SYMBOL oversampled hard decisions into one PHY bit by
// majority vote. Ties resolve to the center sample, or to the most recent
// sample when the symbol ended before the center was reached. A last-marked
// sample closes a short symbol early; sync drops the symbol in progress.
module bit_majority_downsample #(
    parameter int SAMPLE_PER_SYMBOL = 8
) (
    input  logic clk,
    input  logic rst_n,
    input  logic sample,
    input  logic sample_valid,
    input  logic sample_valid_last,
    input  logic sync,
    output logic phy_bit,
    output logic bit_valid,
    output logic bit_valid_last,
    output logic bit_partial
);

    localparam int CW = $clog2(SAMPLE_PER_SYMBOL);
    localparam logic [CW-1:0] CENTER_IDX = CW'(SAMPLE_PER_SYMBOL / 2);
    localparam logic [CW-1:0] LAST_IDX   = CW'(SAMPLE_PER_SYMBOL - 1);

    typedef enum logic {IDLE, ACC} state_t;

    state_t        state;
    logic [CW-1:0] cnt;
    logic [CW:0]   ones;        // wide enough to hold a full symbol of ones
    logic          center;
    logic          center_vld;

    // per-sample view of the symbol after this cycle's sample is folded in
    logic [CW-1:0] base_cnt;
    logic [CW:0]   base_ones;
    logic          base_cvld;
    logic [CW:0]   ones_n;
    logic          center_n;
    logic          cvld_n;
    logic [CW+1:0] n_cnt;
    logic [CW+1:0] twice_ones;
    logic          complete;
    logic          decide;

    // Fold the incoming sample into the symbol and form the vote.
    // A sync restarts the symbol, so this cycle's sample becomes index 0.
    always_comb begin
        base_cnt   = (sync || state == IDLE) ? '0 : cnt;
        base_ones  = (sync || state == IDLE) ? '0 : ones;
        base_cvld  = (sync || state == IDLE) ? 1'b0 : center_vld;
        ones_n     = base_ones + {{CW{1'b0}}, sample};
        center_n   = center;
        cvld_n     = base_cvld;
        if (base_cnt == CENTER_IDX) begin
            center_n = sample;
            cvld_n   = 1'b1;
        end
        // sync wins over a last marker: the restarted symbol is never emitted here
        complete   = sample_valid && !sync &&
                     (base_cnt == LAST_IDX || sample_valid_last);
        n_cnt      = {2'b00, base_cnt} + {{(CW+1){1'b0}}, 1'b1};
        twice_ones = {ones_n, 1'b0};
        if (twice_ones > n_cnt)
            decide = 1'b1;
        else if (twice_ones < n_cnt)
            decide = 1'b0;
        else
            decide = cvld_n ? center_n : sample;  // completing sample is the most recent
    end

    // Symbol FSM, accumulator and registered bit outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state          <= IDLE;
            cnt            <= '0;
            ones           <= '0;
            center         <= 1'b0;
            center_vld     <= 1'b0;
            phy_bit        <= 1'b0;
            bit_valid      <= 1'b0;
            bit_valid_last <= 1'b0;
            bit_partial    <= 1'b0;
        end else begin
            bit_valid      <= 1'b0;
            bit_valid_last <= 1'b0;
            bit_partial    <= 1'b0;
            if (complete) begin
                phy_bit        <= decide;
                bit_valid      <= 1'b1;
                bit_valid_last <= sample_valid_last;
                bit_partial    <= (base_cnt != LAST_IDX);
                cnt            <= '0;
                ones           <= '0;
                center_vld     <= 1'b0;
                state          <= IDLE;
            end else if (sample_valid) begin
                cnt            <= base_cnt + 1'b1;
                ones           <= ones_n;
                center         <= center_n;
                center_vld     <= cvld_n;
                state          <= ACC;
            end else if (sync) begin
                cnt            <= '0;
                ones           <= '0;
                center_vld     <= 1'b0;
                state          <= IDLE;
            end
        end
    end

endmodule
